// File: rtl/bus_pkg.sv
// Shared system-bus widths, memory-slave state encoding and address decode helper.
// Pure declarations; no timing or backpressure of its own.
package bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    TURN = 2'd3
  } slv_state_t;

  // Compared in 33 bits so a window ending at the top of the address space cannot wrap.
  function automatic logic addr_hit(input logic [BUS_AW-1:0] addr,
                                    input logic [BUS_AW-1:0] base,
                                    input int unsigned       depth);
    logic [BUS_AW:0] top;
    top = {1'b0, base} + (BUS_AW+1)'(depth);
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < top);
  endfunction

endpackage

// File: rtl/bus_mem_slave_if.sv
// Request side of the shared system bus as seen between the granted master and a memory slave.
// Combinational wires only; data and ready are shared tri-state lines carried alongside as nets.
interface bus_mem_slave_if;
  import bus_pkg::*;

  logic              valid;
  logic [BUS_AW-1:0] address;
  logic              r_w;
  logic              sel;

  modport master (output valid, output address, output r_w, input sel);
  modport slave  (input valid, input address, input r_w, output sel);

endinterface

// File: rtl/slave_mem_array.sv
// DEPTH x 32 storage: synchronous write, asynchronous read.
// Write lands on the clock edge with we high; read data follows raddr with no latency.
module slave_mem_array
  import bus_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BUS_DW-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [BUS_DW-1:0] rdata
);

  logic [BUS_DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_mem_slave.sv
// Word-addressed memory slave on the shared tri-state bus with programmable wait states.
// Ready pulses WAIT_CYCLES+1 cycles after acceptance; valid dropping during WAIT aborts the transfer.
module bus_mem_slave
  import bus_pkg::*;
#(
  parameter logic [BUS_AW-1:0] BASE_ADDR   = 32'd0,
  parameter int                DEPTH       = 64,
  parameter int                WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  bus_mem_slave_if.slave    bus,
  inout  tri   [BUS_DW-1:0] data,
  inout  tri                ready
);

  localparam int         IW      = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  slv_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              rw_q, rw_d;
  logic              hit;
  logic              mem_we;
  logic [BUS_DW-1:0] rdata;

  assign hit = addr_hit(bus.address, BASE_ADDR, DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.valid && hit) begin
          idx_d   = IW'(bus.address - BASE_ADDR);
          rw_d    = bus.r_w;
          cnt_d   = WAIT_LD;
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        // Losing the grant mid-wait abandons the transfer without touching memory.
        if (!bus.valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        mem_we  = rw_q && bus.valid;
        state_d = TURN;
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  slave_mem_array #(
    .DEPTH (DEPTH),
    .AW    (IW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (data),
    .raddr (idx_q),
    .rdata (rdata)
  );

  assign bus.sel = (state_q != IDLE);
  assign ready   = (state_q != IDLE) ? (state_q == RESP) : 1'bz;
  assign data    = ((state_q == RESP) && !rw_q) ? rdata : {BUS_DW{1'bz}};

endmodule

// File: tb/tb_bus_mem_slave.sv
// Four slaves on private buses (different base/depth/wait settings) driven by a master model.
// Released lines read back as their pull value: data all ones, ready zero.
`timescale 1ns/1ps
module tb_bus_mem_slave;
  import bus_pkg::*;

  localparam int N = 4;

  function automatic int wait_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int base_of(input int k);
    return (k == 3) ? 32 : 0;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 3) ? 16 : 64;
  endfunction

  typedef struct packed {
    logic [31:0] cyc;
    logic        rd;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid  [N];
  logic [31:0] addr   [N];
  logic        rw     [N];
  logic        mdrv   [N];
  logic [31:0] mdat   [N];
  logic [31:0] data_s [N];
  logic        ready_s[N];
  logic        sel_s  [N];

  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        expq [N][$];
  logic [31:0] mdl   [N][64];
  bit          known [N][64];
  int          sel_lo[N];
  int          sel_hi[N];
  exp_t        mon_e;
  logic        mon_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : gi
    bus_mem_slave_if bif ();
    tri1 [31:0] data_w;
    tri0        ready_w;

    assign bif.valid   = valid[g];
    assign bif.address = addr[g];
    assign bif.r_w     = rw[g];
    assign data_w      = mdrv[g] ? mdat[g] : 32'bz;
    assign data_s[g]   = data_w;
    assign ready_s[g]  = ready_w;
    assign sel_s[g]    = bif.sel;

    bus_mem_slave #(
      .BASE_ADDR   (32'(base_of(g))),
      .DEPTH       (depth_of(g)),
      .WAIT_CYCLES (wait_of(g))
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif),
      .data  (data_w),
      .ready (ready_w)
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: ready, read data, bus release and sel checked every cycle against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        while (expq[k].size() > 0 && expq[k][0].cyc < 32'(cyc)) void'(expq[k].pop_front());
        mon_exp = (expq[k].size() > 0) && (expq[k][0].cyc == 32'(cyc));
        chk($sformatf("ready%0d", k), 32'(ready_s[k]), 32'(mon_exp));
        chk($sformatf("sel%0d", k), 32'(sel_s[k]), 32'((cyc >= sel_lo[k]) && (cyc <= sel_hi[k])));
        if (mon_exp) begin
          mon_e = expq[k].pop_front();
          if (mon_e.rd) chk($sformatf("rdata%0d", k), data_s[k], mon_e.dat);
        end else if (!mdrv[k]) begin
          chk($sformatf("data_release%0d", k), data_s[k], 32'hFFFF_FFFF);
        end
      end
    end
  end

  // One master transfer; abort_cyc > 0 drops valid during that wait cycle.
  task automatic xfer(input int k, input int a, input bit wr, input logic [31:0] wd, input int abort_cyc);
    int   w;
    int   a0;
    bit   inr;
    bit   got;
    exp_t e;
    w   = wait_of(k);
    inr = (a >= base_of(k)) && (a < base_of(k) + depth_of(k));
    @(posedge clk); #1;
    valid[k] = 1'b1; addr[k] = 32'(a); rw[k] = wr; mdrv[k] = wr; mdat[k] = wd;
    a0 = cyc + 1;
    if (!inr) begin
      repeat (w + 4) @(posedge clk);
      #1;
    end else if (abort_cyc > 0) begin
      sel_lo[k] = a0; sel_hi[k] = a0 + abort_cyc - 1;
      repeat (abort_cyc) @(posedge clk);
      #1;
    end else begin
      sel_lo[k] = a0; sel_hi[k] = a0 + w + 1;
      e.cyc = 32'(a0 + w);
      e.rd  = !wr;
      e.dat = wr ? 32'h0 : mdl[k][a - base_of(k)];
      expq[k].push_back(e);
      if (wr) begin
        mdl[k][a - base_of(k)]   = wd;
        known[k][a - base_of(k)] = 1'b1;
      end
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        got = ready_s[k];
      end
      if (!got) chk($sformatf("timeout%0d", k), 32'(ready_s[k]), 32'd1);
      @(posedge clk); #1;
    end
    valid[k] = 1'b0; mdrv[k] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int   k, a, w;
    bit   wr;
    bit   got;
    exp_t e;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      valid[i] = 1'b0; addr[i] = '0; rw[i] = 1'b0; mdrv[i] = 1'b0; mdat[i] = '0;
      sel_lo[i] = 1; sel_hi[i] = 0;
      for (int j = 0; j < 64; j++) known[i][j] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_sel%0d", i), 32'(sel_s[i]), 32'd0);
      chk($sformatf("rst_ready%0d", i), 32'(ready_s[i]), 32'd0);
      chk($sformatf("rst_data%0d", i), data_s[i], 32'hFFFF_FFFF);
    end
    reset = 1'b0;

    // Write then read back, WAIT_CYCLES=1.
    xfer(0, 15, 1'b1, 32'hA7, 0);
    xfer(0, 15, 1'b0, 32'h0, 0);
    // Latency sweep: WAIT_CYCLES 0 and 3.
    xfer(1, 48, 1'b1, 32'h3322fa43, 0);
    xfer(1, 48, 1'b0, 32'h0, 0);
    xfer(2, 48, 1'b1, 32'h3322fa43, 0);
    xfer(2, 48, 1'b0, 32'h0, 0);
    // Out of range on the BASE=32/DEPTH=16 slave; aliasing would corrupt words 32 and 47.
    xfer(3, 32, 1'b1, 32'h1111_0032, 0);
    xfer(3, 47, 1'b1, 32'h1111_0047, 0);
    xfer(3, 15, 1'b1, 32'hDEAD_0015, 0);
    xfer(3, 48, 1'b1, 32'hDEAD_0048, 0);
    xfer(3, 15, 1'b0, 32'h0, 0);
    xfer(3, 48, 1'b0, 32'h0, 0);
    xfer(3, 32, 1'b0, 32'h0, 0);
    xfer(3, 47, 1'b0, 32'h0, 0);
    // Abort on wait cycle 2.
    xfer(2, 5, 1'b1, 32'h11, 0);
    xfer(2, 5, 1'b1, 32'h55, 2);
    xfer(2, 5, 1'b0, 32'h0, 0);

    // Reset between edges while a read is in RESP.
    @(posedge clk); #1;
    valid[0] = 1'b1; addr[0] = 32'd15; rw[0] = 1'b0; mdrv[0] = 1'b0;
    sel_lo[0] = cyc + 1; sel_hi[0] = cyc + 3;
    e.cyc = 32'(cyc + 1 + wait_of(0)); e.rd = 1'b1; e.dat = mdl[0][15];
    expq[0].push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = ready_s[0];
    end
    if (!got) chk("reset_setup_ready", 32'(ready_s[0]), 32'd1);
    #2;
    reset = 1'b1;
    sel_lo[0] = 1; sel_hi[0] = 0;
    #1;
    chk("midresp_ready", 32'(ready_s[0]), 32'd0);
    chk("midresp_data", data_s[0], 32'hFFFF_FFFF);
    chk("midresp_sel", 32'(sel_s[0]), 32'd0);
    valid[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    xfer(0, 15, 1'b0, 32'h0, 0);
    xfer(0, 20, 1'b1, 32'hCAFE_0020, 0);
    xfer(0, 20, 1'b0, 32'h0, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 80; n++) begin
      k  = $urandom_range(0, N - 1);
      a  = $urandom_range(0, 95);
      wr = 1'($urandom_range(0, 1));
      w  = wait_of(k);
      if (a >= base_of(k) && a < base_of(k) + depth_of(k) && !wr && !known[k][a - base_of(k)]) wr = 1'b1;
      if (w > 0 && $urandom_range(0, 7) == 0) xfer(k, a, wr, $urandom, $urandom_range(1, w));
      else                                    xfer(k, a, wr, $urandom, 0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_mem_slave.md
Name: bus_mem_slave

Overview:
- Word-addressed memory responder on the shared tri-state system bus: address, data, r_w and ready.
- Decodes the address range of the granted master and applies a programmable number of wait states.
- Completes each transfer with a single-cycle ready pulse, driving data on reads and capturing data on writes.
- Sits opposite the bus masters and the arbiter; the arbiter supplies the bus-valid qualifier.

Parameters:
- BASE_ADDR, 32'd0: first byte-independent word address claimed by this slave.
- DEPTH, 64: number of 32-bit words; power of two, 2..1024.
- WAIT_CYCLES, 1: wait cycles inserted before ready; legal range 0..15.

Ports:
- clk, input, 1: system clock; all state updates on posedge.
- reset, input, 1: asynchronous, active-high reset.
- valid, input, 1: from the arbiter; high while a granted master owns address, r_w and data.
- address, input, 32: bus address.
- r_w, input, 1: 1 = write (master drives data), 0 = read (slave drives data).
- data, inout, 32: shared data bus.
- ready, inout, 1: shared completion strobe; tri-stated when this slave is not selected.
- sel, output, 1: debug flag; high while this slave owns a transaction.

Behaviour:
- Address hit: hit = (address >= BASE_ADDR) && (address < BASE_ADDR + DEPTH).
  - Word index = (address - BASE_ADDR), truncated to clog2(DEPTH) bits.
  - The subtraction is 32-bit unsigned; there is no wrap past the top of the range.
- States are IDLE, WAIT, RESP and TURN. Encoding comes from the package.
- Reset (asynchronous) forces the following, taking effect immediately even mid-transfer:
  - state = IDLE, wait counter = 0, latched index and r_w = 0, sel = 0.
  - ready = z, data = z.
  - A write in flight is discarded.
  - Memory contents are not reset.
- IDLE:
  - ready = z, data = z.
  - On posedge with valid && hit: latch the index and r_w, load wait counter = WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, otherwise RESP.
  - valid with no hit: stay in IDLE and never drive the bus.
- WAIT:
  - sel = 1, ready driven 0, data = z.
  - Counter decrements each posedge; at counter == 1 go to RESP.
  - If valid is low at a posedge: abort to IDLE, no memory access.
- RESP (exactly one cycle):
  - sel = 1, ready driven 1.
  - Read: data is driven with mem[latched index], combinational from the array.
  - Write: data = z; at the posedge ending RESP, mem[index] <= data when valid is high.
  - valid low during RESP: the write is suppressed.
  - Always go to TURN.
- TURN (exactly one cycle):
  - ready driven 0, data = z, sel = 1.
  - Bus turnaround: the master has just advanced its request pointer and may present a new address.
  - Always go to IDLE.
- Latency from the edge that accepts the transfer:
  - ready rises WAIT_CYCLES+1 cycles after acceptance.
  - Back-to-back transfers to this slave cost WAIT_CYCLES+3 cycles each.
- Latched index and r_w are used during WAIT and RESP. Address or r_w changes after acceptance are ignored.
- The slave never drives data while r_w = 1, and never drives data outside RESP.

Decomposition:
- Package bus_pkg holds:
  - BUS_AW = 32 and BUS_DW = 32.
  - Slave state encoding: IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2, TURN = 2'd3.
  - A function addr_hit(addr, base, depth).
- Sub-module slave_mem_array(clk, we, waddr, wdata, raddr, rdata):
  - DEPTH x 32, synchronous write, asynchronous read.
  - Instantiated once.

Test Plan:
- Write, WAIT_CYCLES=1, BASE=0:
  - Stimulus: valid=1, address=15, r_w=1, data=32'hA7.
  - Required: ready=0 for 1 cycle, then 1 for one cycle, then 0 (TURN), then z. mem[15] = 32'hA7.
- Read-back of the same address:
  - Stimulus: r_w=0, address=15.
  - Required: data = 32'hA7 exactly during the ready-high cycle; data = z in all other cycles.
- Latency sweep with WAIT_CYCLES = 0 and 3, write 32'h3322fa43 to address 48:
  - Required: ready high on cycle 1 and cycle 4 after acceptance respectively.
  - Read of address 48 returns 32'h3322fa43.
- Out of range, BASE=32, DEPTH=16:
  - Stimulus: address=15 or address=48, read or write.
  - Required: ready and data stay z, sel=0, memory unchanged.
- Abort:
  - Stimulus: WAIT_CYCLES=3, drop valid on wait cycle 2 of a write of 32'h55 to address 5.
  - Required: return to IDLE, ready never 1, mem[5] unchanged.
- Reset mid-RESP of a read:
  - Stimulus: assert reset asynchronously between edges.
  - Required: ready and data go z immediately, sel=0. After release, a new transfer completes normally.
